// File: rtl/sram_burst_ctrl.sv
// Clocked controller for an asynchronous 16-bit SRAM. Each host transaction is split into BEATS
// consecutive SRAM accesses of ACCESS_CYCLES cycles each, with byte masking and a turnaround after reads.
module sram_burst_ctrl #(
    parameter int ADDR_W        = 18,
    parameter int BEATS         = 2,
    parameter int ACCESS_CYCLES = 2,
    parameter int TURNAROUND    = 1
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                iREQ,
    output logic                oREADY,
    input  logic                iWE,
    input  logic [ADDR_W-1:0]   iADDR,
    input  logic [16*BEATS-1:0] iWDATA,
    input  logic [2*BEATS-1:0]  iBE_N,
    output logic [16*BEATS-1:0] oRDATA,
    output logic                oRVALID,
    output logic [ADDR_W-1:0]   SRAM_ADDR,
    inout  wire  [15:0]         SRAM_DQ,
    output logic                SRAM_CE_N,
    output logic                SRAM_OE_N,
    output logic                SRAM_WE_N,
    output logic                SRAM_UB_N,
    output logic                SRAM_LB_N
);

    // state  | meaning
    // IDLE   | bus parked, strobes high, ready for a request
    // ACCESS | sequencing beat beat_q, cyc_q cycles left in the beat
    // TURN   | post-read bus turnaround, strobes high, DQ released
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_TURN} state_t;

    localparam int HOST_W = 16*BEATS;
    localparam int KW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int MAXC   = (ACCESS_CYCLES > TURNAROUND) ? ACCESS_CYCLES : TURNAROUND;
    localparam int CW     = $clog2(MAXC + 1);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BEATS - 1);
    localparam logic [KW-1:0]     LAST_BEAT  = KW'(BEATS - 1);
    localparam logic [CW-1:0]     ACC_LOAD   = CW'(ACCESS_CYCLES - 1);
    localparam logic [CW-1:0]     TURN_LOAD  = CW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

    state_t              state_q, state_d;
    logic [KW-1:0]       beat_q, beat_d;
    logic [CW-1:0]       cyc_q, cyc_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [HOST_W-1:0]   wdata_q, wdata_d;
    logic [2*BEATS-1:0]  be_n_q, be_n_d;
    logic [HOST_W-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         dq_out_q, dq_out_d;
    logic                dq_oe_q, dq_oe_d;
    logic                ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic                ub_n_q, ub_n_d;
    logic                lb_n_q, lb_n_d;
    logic [1:0]          beat_be_n;

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        cyc_d    = cyc_q;
        we_d     = we_q;
        base_d   = base_q;
        wdata_d  = wdata_q;
        be_n_d   = be_n_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (iREQ) begin
                    state_d = ST_ACCESS;
                    beat_d  = '0;
                    cyc_d   = ACC_LOAD;
                    we_d    = iWE;
                    base_d  = iADDR & ~ALIGN_MASK;
                    wdata_d = iWDATA;
                    be_n_d  = iBE_N;
                end
            end
            ST_ACCESS: begin
                if (!we_q && cyc_q == '0) begin
                    rdata_d[int'(beat_q)*16 +: 16] = SRAM_DQ;
                end
                if (cyc_q != '0) begin
                    cyc_d = cyc_q - CW'(1);
                end else if (beat_q != LAST_BEAT) begin
                    beat_d = beat_q + KW'(1);
                    cyc_d  = ACC_LOAD;
                end else if (we_q) begin
                    state_d = ST_IDLE;
                end else begin
                    rvalid_d = 1'b1;
                    if (TURNAROUND > 0) begin
                        state_d = ST_TURN;
                        cyc_d   = TURN_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_TURN: begin
                if (cyc_q != '0) begin
                    cyc_d = cyc_q - CW'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pins are derived from the next-state values so they are registered yet aligned with the state.
    always_comb begin
        addr_d    = addr_q;
        dq_out_d  = dq_out_q;
        dq_oe_d   = 1'b0;
        ce_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        ub_n_d    = 1'b1;
        lb_n_d    = 1'b1;
        beat_be_n = be_n_d[int'(beat_d)*2 +: 2];

        if (state_d == ST_ACCESS) begin
            addr_d = base_d | ADDR_W'(beat_d);
            ce_n_d = 1'b0;
            if (we_d) begin
                dq_oe_d  = 1'b1;
                dq_out_d = wdata_d[int'(beat_d)*16 +: 16];
                ub_n_d   = beat_be_n[1];
                lb_n_d   = beat_be_n[0];
                // last cycle of the beat releases WE_N for hold; fully masked beats never strobe
                we_n_d   = (cyc_d == '0) || (&beat_be_n);
            end else begin
                oe_n_d = 1'b0;
                ub_n_d = 1'b0;
                lb_n_d = 1'b0;
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            cyc_q    <= '0;
            we_q     <= 1'b0;
            base_q   <= '0;
            wdata_q  <= '0;
            be_n_q   <= '1;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            addr_q   <= '0;
            dq_out_q <= '0;
            dq_oe_q  <= 1'b0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            ub_n_q   <= 1'b1;
            lb_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            base_q   <= base_d;
            wdata_q  <= wdata_d;
            be_n_q   <= be_n_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            addr_q   <= addr_d;
            dq_out_q <= dq_out_d;
            dq_oe_q  <= dq_oe_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            ub_n_q   <= ub_n_d;
            lb_n_q   <= lb_n_d;
        end
    end

    assign oREADY    = (state_q == ST_IDLE) && !iRST;
    assign oRDATA    = rdata_q;
    assign oRVALID   = rvalid_q;
    assign SRAM_ADDR = addr_q;
    assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign SRAM_CE_N = ce_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_UB_N = ub_n_q;
    assign SRAM_LB_N = lb_n_q;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Bench for sram_burst_ctrl: behavioural async SRAM on the pins plus a host-word reference memory.
module tb_sram_burst_ctrl;

    localparam int ADDR_W = 18;
    localparam int BEATS  = 2;
    localparam int AC     = 2;
    localparam int TURN   = 1;
    localparam int HOST_W = 16*BEATS;
    localparam int BA     = BEATS*AC;
    localparam int NCAP   = BA + TURN + 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                req = 1'b0;
    logic                we  = 1'b0;
    logic [ADDR_W-1:0]   addr = '0;
    logic [HOST_W-1:0]   wdata = '0;
    logic [2*BEATS-1:0]  be_n = '0;
    logic                ready;
    logic                rvalid;
    logic [HOST_W-1:0]   rdata;
    logic [ADDR_W-1:0]   s_addr;
    wire  [15:0]         s_dq;
    logic                s_ce_n, s_oe_n, s_we_n, s_ub_n, s_lb_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_burst_ctrl #(
        .ADDR_W(ADDR_W), .BEATS(BEATS), .ACCESS_CYCLES(AC), .TURNAROUND(TURN)
    ) dut (
        .iCLK(clk), .iRST(rst), .iREQ(req), .oREADY(ready), .iWE(we), .iADDR(addr),
        .iWDATA(wdata), .iBE_N(be_n), .oRDATA(rdata), .oRVALID(rvalid),
        .SRAM_ADDR(s_addr), .SRAM_DQ(s_dq), .SRAM_CE_N(s_ce_n), .SRAM_OE_N(s_oe_n),
        .SRAM_WE_N(s_we_n), .SRAM_UB_N(s_ub_n), .SRAM_LB_N(s_lb_n)
    );

    // Behavioural asynchronous SRAM
    logic [15:0] sram_mem [int];
    logic [15:0] model_q = '0;
    logic [15:0] model_w;
    assign s_dq = (!s_ce_n && !s_oe_n && s_we_n) ? model_q : 16'hzzzz;

    always @(negedge clk) begin
        if (!rst && !s_ce_n && !s_we_n) begin
            model_w = sram_mem.exists(int'(s_addr)) ? sram_mem[int'(s_addr)] : 16'h0;
            if (!s_lb_n) model_w[7:0]  = s_dq[7:0];
            if (!s_ub_n) model_w[15:8] = s_dq[15:8];
            sram_mem[int'(s_addr)] = model_w;
        end
        model_q <= sram_mem.exists(int'(s_addr)) ? sram_mem[int'(s_addr)] : 16'h0;
    end

    // Reference memory at host-word level
    logic [15:0] ref_mem [int];

    function automatic int align(input logic [ADDR_W-1:0] a);
        return int'(a) - (int'(a) % BEATS);
    endfunction

    function automatic logic [HOST_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        logic [HOST_W-1:0] r;
        int b;
        r = '0;
        b = align(a);
        for (int k = 0; k < BEATS; k++)
            r[16*k +: 16] = ref_mem.exists(b + k) ? ref_mem[b + k] : 16'h0;
        return r;
    endfunction

    task automatic ref_write(input logic [ADDR_W-1:0] a, input logic [HOST_W-1:0] d,
                             input logic [2*BEATS-1:0] bn);
        logic [15:0] w;
        int b;
        b = align(a);
        for (int k = 0; k < BEATS; k++) begin
            w = ref_mem.exists(b + k) ? ref_mem[b + k] : 16'h0;
            if (!bn[2*k])   w[7:0]  = d[16*k +: 8];
            if (!bn[2*k+1]) w[15:8] = d[16*k+8 +: 8];
            ref_mem[b + k] = w;
        end
    endtask

    // Per-cycle pin capture; index n = n-th cycle after the accept edge
    logic [ADDR_W-1:0] c_addr   [0:NCAP];
    logic [15:0]       c_dq     [0:NCAP];
    logic              c_ce_n   [0:NCAP];
    logic              c_oe_n   [0:NCAP];
    logic              c_we_n   [0:NCAP];
    logic              c_ub_n   [0:NCAP];
    logic              c_lb_n   [0:NCAP];
    logic              c_ready  [0:NCAP];
    logic              c_rvalid [0:NCAP];
    logic [HOST_W-1:0] c_rdata  [0:NCAP];

    task automatic run_txn(input logic t_we, input logic [ADDR_W-1:0] t_addr,
                           input logic [HOST_W-1:0] t_wdata, input logic [2*BEATS-1:0] t_be_n);
        int waitc;
        @(negedge clk);
        req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata; be_n = t_be_n;
        waitc = 0;
        while (ready !== 1'b1 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: oREADY=%b after %0d cycles, required 1", ready, waitc);
            req = 1'b0;
            return;
        end
        for (int n = 1; n <= NCAP; n++) begin
            @(negedge clk);
            if (n == 1) req = 1'b0;
            c_addr[n] = s_addr;  c_dq[n] = s_dq;      c_ce_n[n] = s_ce_n;
            c_oe_n[n] = s_oe_n;  c_we_n[n] = s_we_n;  c_ub_n[n] = s_ub_n;
            c_lb_n[n] = s_lb_n;  c_ready[n] = ready;  c_rvalid[n] = rvalid;
            c_rdata[n] = rdata;
        end
        if (t_we) ref_write(t_addr, t_wdata, t_be_n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({s_ce_n, s_oe_n, s_we_n, s_ub_n, s_lb_n} !== 5'b11111) begin
            errors++;
            $display("FAIL reset_strobes: got %b required 11111", {s_ce_n, s_oe_n, s_we_n, s_ub_n, s_lb_n});
        end
        checks++;
        if (s_addr !== '0) begin
            errors++; $display("FAIL reset_addr: got %h required 0", s_addr);
        end
        checks++;
        if (ready !== 1'b0 || rvalid !== 1'b0 || rdata !== '0) begin
            errors++;
            $display("FAIL reset_host: ready=%b rvalid=%b rdata=%h required 0 0 0", ready, rvalid, rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b required 1", ready);
        end
    endtask

    task automatic test_write_directed();
        logic [HOST_W-1:0] d;
        d = 32'hBEEF_1234;
        run_txn(1'b1, 18'h00101, d, 4'b0000);
        for (int n = 1; n <= BA; n++) begin
            int beat;
            logic [ADDR_W-1:0] ea;
            logic [15:0] ed;
            logic ewe;
            beat = (n - 1) / AC;
            ea   = ADDR_W'(18'h00100 + beat);
            ed   = d[16*beat +: 16];
            ewe  = ((n - 1) % AC) == (AC - 1);
            checks++;
            if (c_addr[n] !== ea || c_dq[n] !== ed || c_we_n[n] !== ewe || c_ce_n[n] !== 1'b0) begin
                errors++;
                $display("FAIL wr_cycle%0d: addr=%h dq=%h we_n=%b ce_n=%b required %h %h %b 0",
                         n, c_addr[n], c_dq[n], c_we_n[n], c_ce_n[n], ea, ed, ewe);
            end
        end
        checks++;
        if (c_ready[BA] !== 1'b0 || c_ready[BA+1] !== 1'b1) begin
            errors++;
            $display("FAIL wr_ready: cyc%0d=%b cyc%0d=%b required 0 1", BA, c_ready[BA], BA+1, c_ready[BA+1]);
        end
    endtask

    task automatic test_read_directed();
        run_txn(1'b0, 18'h00101, '0, '0);
        checks++;
        if (c_rvalid[BA] !== 1'b0 || c_rvalid[BA+1] !== 1'b1 || c_rvalid[BA+2] !== 1'b0) begin
            errors++;
            $display("FAIL rd_rvalid_pulse: %b%b%b required 010", c_rvalid[BA], c_rvalid[BA+1], c_rvalid[BA+2]);
        end
        checks++;
        if (c_rdata[BA+1] !== 32'hBEEF_1234) begin
            errors++; $display("FAIL rd_data: got %h required beef1234", c_rdata[BA+1]);
        end
        checks++;
        if (c_ready[BA+TURN] !== 1'b0 || c_ready[BA+TURN+1] !== 1'b1) begin
            errors++;
            $display("FAIL rd_ready: %b%b required 01", c_ready[BA+TURN], c_ready[BA+TURN+1]);
        end
        for (int n = 1; n <= BA; n++) begin
            checks++;
            if (c_oe_n[n] !== 1'b0 || c_we_n[n] !== 1'b1 || c_ub_n[n] !== 1'b0 || c_lb_n[n] !== 1'b0) begin
                errors++;
                $display("FAIL rd_strobes_cyc%0d: oe_n=%b we_n=%b ub_n=%b lb_n=%b required 0 1 0 0",
                         n, c_oe_n[n], c_we_n[n], c_ub_n[n], c_lb_n[n]);
            end
        end
        checks++;
        if (c_oe_n[BA+1] !== 1'b1 || c_ce_n[BA+1] !== 1'b1) begin
            errors++;
            $display("FAIL rd_turn_strobes: oe_n=%b ce_n=%b required 1 1", c_oe_n[BA+1], c_ce_n[BA+1]);
        end
    endtask

    task automatic test_masked_write();
        logic [HOST_W-1:0] d;
        d = HOST_W'($urandom());
        run_txn(1'b1, 18'h00100, d, 4'b1110);
        checks++;
        if (c_we_n[1] !== 1'b0 || c_lb_n[1] !== 1'b0 || c_ub_n[1] !== 1'b1) begin
            errors++;
            $display("FAIL mask_beat0: we_n=%b lb_n=%b ub_n=%b required 0 0 1", c_we_n[1], c_lb_n[1], c_ub_n[1]);
        end
        checks++;
        if (c_we_n[AC+1] !== 1'b1 || c_we_n[AC+2] !== 1'b1) begin
            errors++;
            $display("FAIL mask_beat1_we: %b%b required 11", c_we_n[AC+1], c_we_n[AC+2]);
        end
        run_txn(1'b0, 18'h00100, '0, '0);
        checks++;
        if (c_rdata[BA+1] !== {16'hBEEF, 8'h12, d[7:0]}) begin
            errors++;
            $display("FAIL mask_readback: got %h required %h", c_rdata[BA+1], {16'hBEEF, 8'h12, d[7:0]});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic              t_we;
            logic [ADDR_W-1:0] t_a;
            logic [HOST_W-1:0] t_d, exp;
            logic [2*BEATS-1:0] t_bn;
            int nwe, ewe;
            t_we = 1'(($urandom() % 2));
            t_a  = ADDR_W'(18'h00200 + $urandom_range(0, 7));
            t_d  = HOST_W'({$urandom(), $urandom()});
            t_bn = (2*BEATS)'($urandom());
            exp  = ref_read(t_a);
            run_txn(t_we, t_a, t_d, t_bn);
            checks++;
            if (c_addr[1] !== ADDR_W'(align(t_a))) begin
                errors++; $display("FAIL rnd%0d_base: got %h required %h", i, c_addr[1], align(t_a));
            end
            if (t_we) begin
                nwe = 0; ewe = 0;
                for (int n = 1; n <= BA; n++) if (c_we_n[n] === 1'b0) nwe++;
                for (int k = 0; k < BEATS; k++) if (t_bn[2*k +: 2] != 2'b11) ewe += AC - 1;
                checks++;
                if (nwe != ewe || c_ready[BA] !== 1'b0 || c_ready[BA+1] !== 1'b1) begin
                    errors++;
                    $display("FAIL rnd%0d_write: we_low=%0d ready=%b%b required %0d 01",
                             i, nwe, c_ready[BA], c_ready[BA+1], ewe);
                end
            end else begin
                checks++;
                if (c_rvalid[BA+1] !== 1'b1 || c_rdata[BA+1] !== exp || c_ready[BA+TURN+1] !== 1'b1) begin
                    errors++;
                    $display("FAIL rnd%0d_read: rvalid=%b rdata=%h ready=%b required 1 %h 1",
                             i, c_rvalid[BA+1], c_rdata[BA+1], c_ready[BA+TURN+1], exp);
                end
            end
        end
    endtask

    task automatic test_read_then_write();
        logic [ADDR_W-1:0] ra, wa;
        logic [HOST_W-1:0] exp, wd, rd_seen;
        int waitc, acc, last_oe, first_wr, viol;
        logic prev_oe_n;
        ra = 18'h00100; wa = 18'h00300;
        wd = HOST_W'($urandom());
        exp = ref_read(ra);
        rd_seen = '0;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = ra;
        waitc = 0;
        while (ready !== 1'b1 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        acc = -1; last_oe = -1; first_wr = -1; viol = 0; prev_oe_n = 1'b1;
        for (int i = 1; i <= 4*NCAP; i++) begin
            @(negedge clk);
            if (i == 1) begin we = 1'b1; addr = wa; wdata = wd; be_n = '0; end
            if (s_oe_n === 1'b0) last_oe = i;
            if (s_ce_n === 1'b0 && s_oe_n === 1'b1 && first_wr < 0) first_wr = i;
            if (prev_oe_n === 1'b0 && s_ce_n === 1'b0 && s_oe_n === 1'b1) viol++;
            if (s_oe_n === 1'b0 && s_we_n === 1'b0) viol++;
            if (rvalid === 1'b1) rd_seen = rdata;
            if (acc > 0 && i == acc + 1) req = 1'b0;
            if (acc < 0 && i > 1 && ready === 1'b1) acc = i;
            prev_oe_n = s_oe_n;
        end
        req = 1'b0;
        ref_write(wa, wd, '0);
        checks++;
        if (acc != BA + TURN + 1) begin
            errors++; $display("FAIL rw_accept_cycle: got %0d required %0d", acc, BA + TURN + 1);
        end
        checks++;
        if (last_oe != BA || first_wr != BA + TURN + 2) begin
            errors++;
            $display("FAIL rw_bus_gap: last_oe=%0d first_wr=%0d required %0d %0d", last_oe, first_wr, BA, BA+TURN+2);
        end
        checks++;
        if (viol != 0) begin
            errors++; $display("FAIL rw_contention: %0d cycles required 0", viol);
        end
        checks++;
        if (rd_seen !== exp) begin
            errors++; $display("FAIL rw_read_data: got %h required %h", rd_seen, exp);
        end
        run_txn(1'b0, wa, '0, '0);
        checks++;
        if (c_rdata[BA+1] !== wd) begin
            errors++; $display("FAIL rw_write_landed: got %h required %h", c_rdata[BA+1], wd);
        end
    endtask

    task automatic test_reset_mid_read();
        int waitc, pulses;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 18'h00100;
        waitc = 0;
        while (ready !== 1'b1 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        @(negedge clk); req = 1'b0;
        repeat (AC) @(negedge clk);
        checks++;
        if (s_ce_n !== 1'b0 || s_addr !== 18'h00101) begin
            errors++; $display("FAIL rst_mid_in_beat1: ce_n=%b addr=%h required 0 00101", s_ce_n, s_addr);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({s_ce_n, s_oe_n, s_we_n, s_ub_n, s_lb_n} !== 5'b11111 || ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: strobes=%b ready=%b required 11111 0",
                     {s_ce_n, s_oe_n, s_we_n, s_ub_n, s_lb_n}, ready);
        end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 2*NCAP; i++) begin
            @(negedge clk);
            if (rvalid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || rdata !== '0) begin
            errors++; $display("FAIL rst_mid_no_result: rvalid_pulses=%0d rdata=%h required 0 0", pulses, rdata);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_directed();
        test_read_directed();
        test_masked_write();
        test_random();
        test_read_then_write();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
